ncpu32k_bus_arb: RTL
====================

NCPU32K_BUS_ARB -- requirements
Module: ncpu32k_bus_arb

Interface
REQ-001 Parameter AW, default 32, address width.
REQ-002 Parameter DW, default 32, data width.
REQ-003 clk  in  1  sole clock, all state on rising edge.
REQ-004 rst_n  in  1  asynchronous active-low reset.
REQ-005 m_valid_i  in  2  per-master command valid; bit0 = fetch unit (M0), bit1 = load/store unit (M1).
REQ-006 m_ready_o  out  2  per-master command accepted.
REQ-007 m_addr_i  in  2*AW  per-master address, M0 in [AW-1:0].
REQ-008 m_we_i  in  2  per-master write enable.
REQ-009 m_size_i  in  6  per-master 3-bit access size, M0 in [2:0].
REQ-010 m_wdat_i  in  2*DW  per-master write data.
REQ-011 m_rvalid_o  out  2  per-master response valid.
REQ-012 m_rready_i  in  2  per-master response ready.
REQ-013 m_rdat_o  out  DW  shared read data, qualified by m_rvalid_o.
REQ-014 s_valid_o / s_ready_i  out/in  1/1  slave command handshake.
REQ-015 s_addr_o, s_we_o, s_size_o, s_wdat_o  out  AW/1/3/DW  slave command fields.
REQ-016 s_rvalid_i / s_rready_o  in/out  1/1  slave response handshake.
REQ-017 s_rdat_i  in  DW  slave read data.

Function
REQ-018 The block SHALL share one slave bus between M0 and M1, with at most one outstanding transaction.
REQ-019 FSM states SHALL be IDLE, CMD, RSP; a 1-bit grant register g selects the owning master.
REQ-020 IDLE: if any m_valid_i bit is set, g SHALL be loaded with the winner and state SHALL move to CMD next cycle; no ready/valid output is asserted in IDLE.
REQ-021 Single requester SHALL win; with both requesting, the winner SHALL be the master not served last (round-robin via register last).
REQ-022 CMD: s_valid_o = m_valid_i[g], m_ready_o[g] = s_ready_i, s_addr/we/size/wdat = fields of master g; the other m_ready_o bit SHALL be 0.
REQ-023 CMD: s_valid_o & s_ready_i SHALL move state to RSP; m_valid_i[g] low in CMD (protocol violation) SHALL return to IDLE without updating last.
REQ-024 RSP: m_rvalid_o[g] = s_rvalid_i, s_rready_o = m_rready_i[g], m_rdat_o = s_rdat_i; writes SHALL also complete through one response handshake.
REQ-025 RSP: s_rvalid_i & s_rready_o SHALL set last = g and return to IDLE; minimum transaction latency is 3 cycles (IDLE, CMD, RSP).
REQ-026 Requests arriving while not IDLE SHALL stall (m_ready_o low) until the next IDLE arbitration.
REQ-027 Slave command fields SHALL be 0 outside CMD; m_rdat_o SHALL pass s_rdat_i unconditionally.

Reset
REQ-028 rst_n low SHALL immediately force state = IDLE, g = 0, last = 1 (M0 wins first tie), all valid/ready outputs 0, including mid-transaction.
REQ-029 After rst_n release, the first arbitration SHALL occur on the first rising edge with a request.

Configuration
REQ-030 Macro NCPU_BUS_ARB_FIXED_PRIO_EN defined: ties SHALL always grant M1 (load/store), and last is unused.
REQ-031 Macro undefined: round-robin per REQ-021.

Verification
REQ-032 M0 read addr 0x100, slave s_ready_i=1 immediately, s_rvalid_i next cycle with 0xDEADBEEF -> m_rvalid_o=01, m_rdat_o=0xDEADBEEF, state IDLE after 3 cycles.
REQ-033 Both masters valid continuously after reset, 4 transactions -> grant order M0,M1,M0,M1 (fixed-prio build: M1,M1,M1,M1).
REQ-034 M1 write addr 0x200 data 0x55AA, s_ready_i held low 5 cycles -> s_valid_o high and stable for 6 cycles, m_ready_o=10 only on the accept cycle.
REQ-035 M0 in RSP with m_rready_i[0]=0 for 3 cycles while s_rvalid_i=1 -> s_rready_o=0, no return to IDLE until m_rready_i[0]=1.
REQ-036 rst_n asserted during CMD with s_valid_o=1 -> s_valid_o, m_ready_o, m_rvalid_o all 0 the same cycle; next transaction after release grants M0 on tie.

Source files
------------

// File: rtl/ncpu32k_bus_arb.sv
// Two-master (fetch M0, load/store M1) arbiter onto one slave bus, one transaction in flight.
// Define NCPU_BUS_ARB_FIXED_PRIO_EN to make ties always grant M1 instead of round-robin.
module ncpu32k_bus_arb #(
   parameter int AW = 32,
   parameter int DW = 32
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic [1:0]      m_valid_i,
   output logic [1:0]      m_ready_o,
   input  logic [2*AW-1:0] m_addr_i,
   input  logic [1:0]      m_we_i,
   input  logic [5:0]      m_size_i,
   input  logic [2*DW-1:0] m_wdat_i,
   output logic [1:0]      m_rvalid_o,
   input  logic [1:0]      m_rready_i,
   output logic [DW-1:0]   m_rdat_o,
   output logic            s_valid_o,
   input  logic            s_ready_i,
   output logic [AW-1:0]   s_addr_o,
   output logic            s_we_o,
   output logic [2:0]      s_size_o,
   output logic [DW-1:0]   s_wdat_o,
   input  logic            s_rvalid_i,
   output logic            s_rready_o,
   input  logic [DW-1:0]   s_rdat_i
);

   typedef enum logic [1:0] {IDLE, CMD, RSP} state_t;

   state_t state, state_nxt;
   logic   g, g_nxt;
   logic   winner;

`ifdef NCPU_BUS_ARB_FIXED_PRIO_EN
   // M1 wins whenever it requests; M0 only when alone.
   assign winner = m_valid_i[1];
`else
   logic last, last_nxt;

   assign winner = (&m_valid_i) ? ~last : m_valid_i[1];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) last <= 1'b1;
      else        last <= last_nxt;
   end
`endif

   // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         g     <= 1'b0;
      end else begin
         state <= state_nxt;
         g     <= g_nxt;
      end
   end

   assign m_rdat_o = s_rdat_i;

   // NOTE: every output and next-state value gets a default first so no latch is inferred.
   always_comb begin
      state_nxt  = state;
      g_nxt      = g;
`ifndef NCPU_BUS_ARB_FIXED_PRIO_EN
      last_nxt   = last;
`endif
      m_ready_o  = 2'b00;
      m_rvalid_o = 2'b00;
      s_valid_o  = 1'b0;
      s_addr_o   = '0;
      s_we_o     = 1'b0;
      s_size_o   = 3'd0;
      s_wdat_o   = '0;
      s_rready_o = 1'b0;

      case (state)
         IDLE: begin
            if (|m_valid_i) begin
               g_nxt     = winner;
               state_nxt = CMD;
            end
         end
         CMD: begin
            s_valid_o = m_valid_i[g];
            s_addr_o  = g ? m_addr_i[2*AW-1:AW] : m_addr_i[AW-1:0];
            s_we_o    = m_we_i[g];
            s_size_o  = g ? m_size_i[5:3] : m_size_i[2:0];
            s_wdat_o  = g ? m_wdat_i[2*DW-1:DW] : m_wdat_i[DW-1:0];
            m_ready_o = g ? {s_ready_i, 1'b0} : {1'b0, s_ready_i};
            // A master dropping valid mid-command abandons the slot without counting as served.
            if (!m_valid_i[g])   state_nxt = IDLE;
            else if (s_ready_i)  state_nxt = RSP;
         end
         RSP: begin
            m_rvalid_o = g ? {s_rvalid_i, 1'b0} : {1'b0, s_rvalid_i};
            s_rready_o = m_rready_i[g];
            if (s_rvalid_i && m_rready_i[g]) begin
`ifndef NCPU_BUS_ARB_FIXED_PRIO_EN
               last_nxt = g;
`endif
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

endmodule
